// File: rtl/scoreboard_ssd_driver.sv
// -----------------------------------------------------------------------------
// scoreboard_ssd_driver
//
// Drives a 4-digit multiplexed, active-low seven-segment display from the game
// controller's score and lives outputs. A free-running refresh counter walks
// the four digit slots, with a short blanking window at the start of each slot
// to avoid ghosting. The inputs are captured into shadow registers once per
// scan frame, so a frame never shows a mix of old and new values. The lives
// digit flashes for a number of frames after a life is lost, "LOSE" is shown
// in the lose state, and the whole display blinks in the win state.
//
// State table:
//   SCAN  | normal display: lives, dash, tens, ones (left to right)
//   FLASH | as SCAN, lives digit blank on frames where flash_cnt[0]=1
//   LOSE  | shows "LOSE"
//   WIN   | as SCAN, all digits blank on frames where the parity bit is 1
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   score_ones  in   [3:0] BCD score units digit
//   score_tens  in   [3:0] BCD score tens digit
//   lives       in   [3:0] remaining lives, binary
//   game_over   in   level, controller is in its LOSE state
//   game_won    in   level, controller is in its WIN state
//   an          out  [3:0] anode enables, active-low, an[0] = rightmost digit
//   ssd         out  [6:0] segments {G,F,E,D,C,B,A}, active-low
//   dp          out  decimal point, active-low, always off
//
// Build option:
//   SSD_LZ_BLANK_EN  when defined, a tens digit of 0 is shown blank in
//                    SCAN, FLASH and WIN; otherwise it is shown as "0".
// -----------------------------------------------------------------------------
module scoreboard_ssd_driver #(
    parameter int CNT_W        = 20,
    parameter int DEAD_BITS    = 8,
    parameter int FLASH_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] score_ones,
    input  logic [3:0] score_tens,
    input  logic [3:0] lives,
    input  logic       game_over,
    input  logic       game_won,
    output logic [3:0] an,
    output logic [6:0] ssd,
    output logic       dp
);

    localparam int SLOT_W = CNT_W - 2;
    localparam logic [SLOT_W-1:0] DEAD_LIM = {{(SLOT_W-1){1'b0}}, 1'b1} << DEAD_BITS;
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        S_SCAN  = 2'd0,
        S_FLASH = 2'd1,
        S_LOSE  = 2'd2,
        S_WIN   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic [3:0]       r_lives;
    logic [3:0]       r_lives_prev;
    logic             r_over;
    logic             r_won;
    logic [7:0]       r_flash_cnt;
    logic             r_parity;
    logic [3:0]       r_an;
    logic [6:0]       r_ssd;
    logic             r_dp;

    logic             w_frame_end;
    logic [1:0]       w_slot;
    logic             w_dead;
    logic             w_lives_drop;
    logic [6:0]       w_tens_seg;
    logic [6:0]       w_lives_seg;
    logic [3:0]       w_an;
    logic [6:0]       w_ssd;

    // Anything outside 0..9 (including X from an unreset controller) is blank.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign w_frame_end = &r_cnt;
    assign w_slot      = r_cnt[CNT_W-1:CNT_W-2];
    assign w_dead      = r_cnt[SLOT_W-1:0] < DEAD_LIM;

    // Compared against the value being loaded this boundary; the current lives
    // shadow becomes lives_prev. An out-of-range previous value never flashes.
    assign w_lives_drop = (r_lives <= 4'd9) && (lives < r_lives);

    always_comb begin
        w_tens_seg = seg7(r_tens);
`ifdef SSD_LZ_BLANK_EN
        if (r_tens == 4'd0) begin
            w_tens_seg = SEG_BLANK;
        end
`endif
        w_lives_seg = seg7(r_lives);
        if (r_state == S_FLASH && r_flash_cnt[0]) begin
            w_lives_seg = SEG_BLANK;
        end

        if (r_state == S_LOSE) begin
            case (w_slot)
                2'd0:    w_ssd = SEG_E;
                2'd1:    w_ssd = SEG_S;
                2'd2:    w_ssd = SEG_O;
                default: w_ssd = SEG_L;
            endcase
        end else begin
            case (w_slot)
                2'd0:    w_ssd = seg7(r_ones);
                2'd1:    w_ssd = w_tens_seg;
                2'd2:    w_ssd = SEG_DASH;
                default: w_ssd = w_lives_seg;
            endcase
            if (r_state == S_WIN && r_parity) begin
                w_ssd = SEG_BLANK;
            end
        end

        w_an = ~(4'b0001 << w_slot);
        if (w_dead) begin
            w_an  = 4'b1111;
            w_ssd = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_SCAN;
            r_cnt        <= '0;
            r_ones       <= '0;
            r_tens       <= '0;
            r_lives      <= '0;
            r_lives_prev <= '0;
            r_over       <= 1'b0;
            r_won        <= 1'b0;
            r_flash_cnt  <= '0;
            r_parity     <= 1'b0;
            r_an         <= 4'b1111;
            r_ssd        <= SEG_BLANK;
            r_dp         <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_an  <= w_an;
            r_ssd <= w_ssd;
            r_dp  <= 1'b1;

            if (w_frame_end) begin
                r_ones       <= score_ones;
                r_tens       <= score_tens;
                r_lives      <= lives;
                r_lives_prev <= r_lives;
                r_over       <= game_over;
                r_won        <= game_won;

                if (game_over) begin
                    r_state <= S_LOSE;
                end else if (game_won) begin
                    // First WIN frame is visible; parity flips on every
                    // boundary spent in WIN after that.
                    r_parity <= (r_state == S_WIN) ? ~r_parity : 1'b0;
                    r_state  <= S_WIN;
                end else begin
                    case (r_state)
                        S_SCAN, S_FLASH: begin
                            if (w_lives_drop) begin
                                r_state     <= S_FLASH;
                                r_flash_cnt <= FLASH_LOAD;
                            end else if (r_state == S_FLASH) begin
                                if (r_flash_cnt == 8'd0) begin
                                    r_state <= S_SCAN;
                                end else begin
                                    r_flash_cnt <= r_flash_cnt - 8'd1;
                                end
                            end
                        end
                        default: r_state <= S_SCAN;
                    endcase
                end
            end
        end
    end

    assign an  = r_an;
    assign ssd = r_ssd;
    assign dp  = r_dp;

endmodule
